turnstile_gate_responder: RTL and testbench

Gate-side end of the turnstile control interface. It receives the level-coded direction command (enter/exit) from the gate controller, unlocks the arm, debounces the passenger push key, times the arm rotation, and returns a one-cycle passage-sensor pulse to the controller. It also keeps a saturating occupancy count, shown on a 7-segment digit, and flags rejected or timed-out requests on the red LED.

---
 rtl/turnstile_gate_responder.sv | 95 +++++++++
 tb/tb_turnstile_gate_responder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/turnstile_gate_responder.sv
// turnstile_gate_responder: gate-side turnstile responder (arm unlock, key debounce, rotation timing, occupancy)
// Ports: CLK clock, RST_N async active-low reset, CMD[1]=enter/CMD[0]=exit level command,
//        KEY_N raw active-low push key, SENSOR one-cycle passage pulse, LEDG arm unlocked,
//        LEDR reject/timeout, HEX0 active-low occupancy digit (a..g = [6:0]), OCC binary occupancy.
module turnstile_gate_responder #(
  parameter int DEBOUNCE    = 4,
  parameter int ROT_CYC     = 8,
  parameter int TIMEOUT_CYC = 50,
  parameter int MAX_OCC     = 9
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] CMD,
  input  logic       KEY_N,
  output logic       SENSOR,
  output logic       LEDG,
  output logic       LEDR,
  output logic [6:0] HEX0,
  output logic [3:0] OCC
);
  typedef enum logic [2:0] {LOCKED, ARMED_IN, ARMED_OUT, ROTATING, DONE, WAIT_REL, REJECT, TIMEOUT} state_t;
  localparam int CW = $clog2((TIMEOUT_CYC > ROT_CYC ? TIMEOUT_CYC : ROT_CYC) + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);
  state_t state, state_n;
  logic s1, s2, db, press, dir, db_hit, armed;
  logic [DW-1:0] dcnt;
  logic [CW-1:0] cnt;
  // db_hit marks the cycle where the synchronized level has differed from db long enough
  assign db_hit = (s2 != db) && (dcnt == DW'(DEBOUNCE - 1));
  assign armed = (state == ARMED_IN) || (state == ARMED_OUT);
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      db <= 1'b1;
      dcnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= KEY_N;
      s2 <= s1;
      dcnt <= (s2 != db && !db_hit) ? dcnt + 1'b1 : '0;
      db <= db_hit ? s2 : db;
      press <= db_hit & db;
    end
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= LOCKED;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      LOCKED:
        state_n = (CMD == 2'b10 && OCC < 4'(MAX_OCC)) ? ARMED_IN :
                  (CMD == 2'b01 && OCC != 4'd0)       ? ARMED_OUT :
                  (CMD != 2'b00)                      ? REJECT : LOCKED;
      ARMED_IN, ARMED_OUT:
        state_n = press ? ROTATING : (cnt == CW'(TIMEOUT_CYC - 1)) ? TIMEOUT : state;
      ROTATING: state_n = (cnt == CW'(ROT_CYC - 1)) ? DONE : ROTATING;
      DONE:     state_n = WAIT_REL;
      default:  state_n = (CMD == 2'b00) ? LOCKED : state;
    endcase
  end
  // one shared counter times both the armed window and the rotation; it restarts on every state change
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
      dir <= 1'b0;
      OCC <= 4'd0;
    end else begin
      cnt <= (state_n != state || !(armed || state == ROTATING)) ? '0 : cnt + 1'b1;
      dir <= (armed && press) ? (state == ARMED_IN) : dir;
      if (state_n == DONE && state != DONE)
        OCC <= dir ? (OCC < 4'(MAX_OCC) ? OCC + 4'd1 : OCC) : (OCC != 4'd0 ? OCC - 4'd1 : OCC);
    end
  end
  always_comb begin
    LEDG = (state == ARMED_IN) || (state == ARMED_OUT) || (state == ROTATING);
    LEDR = (state == REJECT) || (state == TIMEOUT);
    SENSOR = (state == DONE);
    case (OCC)
      4'd0:    HEX0 = 7'b0000001;
      4'd1:    HEX0 = 7'b1001111;
      4'd2:    HEX0 = 7'b0010010;
      4'd3:    HEX0 = 7'b0000110;
      4'd4:    HEX0 = 7'b1001100;
      4'd5:    HEX0 = 7'b0100100;
      4'd6:    HEX0 = 7'b0100000;
      4'd7:    HEX0 = 7'b0001111;
      4'd8:    HEX0 = 7'b0000000;
      4'd9:    HEX0 = 7'b0000100;
      default: HEX0 = 7'b1111111;
    endcase
  end
endmodule

// File: tb/tb_turnstile_gate_responder.sv
// tb_turnstile_gate_responder: scoreboard bench with transaction-level occupancy model
module tb_turnstile_gate_responder;
  localparam int DEB = 4, ROT = 8, TMO = 50, MAXO = 9;
  logic CLK = 0, RST_N = 0, KEY_N = 1;
  logic [1:0] CMD = 2'b00;
  logic SENSOR, LEDG, LEDR;
  logic [6:0] HEX0;
  logic [3:0] OCC;
  typedef struct {bit red; int occ;} ev_t;
  ev_t q[$];
  int passed = 0, total = 0, model_occ = 0, k;
  logic ledr_q = 0;
  logic [6:0] seg [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  turnstile_gate_responder #(.DEBOUNCE(DEB), .ROT_CYC(ROT), .TIMEOUT_CYC(TMO), .MAX_OCC(MAXO)) dut (
    .CLK(CLK), .RST_N(RST_N), .CMD(CMD), .KEY_N(KEY_N), .SENSOR(SENSOR),
    .LEDG(LEDG), .LEDR(LEDR), .HEX0(HEX0), .OCC(OCC));
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  function automatic int hex_of(input int v);
    return (v >= 0 && v <= 9) ? int'(seg[v]) : 7'h7f;
  endfunction
  task automatic expect_ev(input bit red);
    ev_t e;
    if (q.size() == 0) begin
      total++;
      $display("FAIL unexpected_event: got %s with OCC=%0d, expected none", red ? "LEDR" : "SENSOR", OCC);
    end else begin
      e = q.pop_front();
      chk("event_kind", red, e.red);
      chk("event_occ", OCC, e.occ);
      chk("event_hex", HEX0, hex_of(e.occ));
    end
  endtask
  always @(negedge CLK) begin
    if (RST_N) begin
      if (SENSOR) expect_ev(1'b0);
      if (LEDR && !ledr_q) expect_ev(1'b1);
    end
    ledr_q = LEDR;
  end
  // mode: 0 = real press, 1 = short glitch, 2 = no key
  task automatic do_txn(input logic [1:0] c, input int mode, input int dly);
    ev_t e;
    bit ok;
    ok = (c == 2'b10 && model_occ < MAXO) || (c == 2'b01 && model_occ > 0);
    if (ok && mode == 0) begin
      model_occ += (c == 2'b10) ? 1 : -1;
      e.red = 0;
    end else e.red = 1;
    e.occ = model_occ;
    q.push_back(e);
    @(negedge CLK) CMD = c;
    repeat (dly) @(negedge CLK);
    if (mode != 2) begin
      KEY_N = 0;
      repeat (mode == 0 ? 10 : 3) @(negedge CLK);
      KEY_N = 1;
    end
    repeat (70) @(negedge CLK);
    CMD = 2'b00;
    repeat (12) @(negedge CLK);
    chk("locked_after_txn", {SENSOR, LEDG, LEDR}, 0);
    chk("occ_track", OCC, model_occ);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_occ", OCC, 0);
    chk("reset_hex", HEX0, 7'b0000001);
    chk("reset_leds", {SENSOR, LEDG, LEDR}, 0);
    RST_N = 1;
    repeat (3) @(negedge CLK);
    model_occ = 1;
    q.push_back('{0, 1});
    CMD = 2'b10;
    @(negedge CLK);
    chk("ledg_armed", LEDG, 1);
    repeat (4) @(negedge CLK);
    KEY_N = 0;
    k = 0;
    while (!SENSOR && k < 40) begin
      @(negedge CLK);
      k++;
      if (k == 10) KEY_N = 1;
    end
    chk("sensor_latency", k, 2 + DEB + 1 + ROT);
    KEY_N = 1;
    @(negedge CLK);
    chk("sensor_one_cycle", SENSOR, 0);
    repeat (5) @(negedge CLK);
    chk("wait_rel_hold", {SENSOR, LEDG, LEDR}, 0);
    CMD = 2'b00;
    repeat (10) @(negedge CLK);
    q.push_back('{1, 1});
    CMD = 2'b10;
    k = 0;
    while (!LEDR && k < 100) begin
      @(negedge CLK);
      k++;
    end
    chk("timeout_latency", k, TMO + 1);
    chk("timeout_occ", OCC, 1);
    CMD = 2'b00;
    repeat (2) @(negedge CLK);
    chk("ledr_clear", LEDR, 0);
    do_txn(2'b01, 0, 3);
    q.push_back('{1, 0});
    CMD = 2'b01;
    @(negedge CLK);
    chk("reject_leds", {LEDG, LEDR}, 2'b01);
    CMD = 2'b00;
    repeat (3) @(negedge CLK);
    do_txn(2'b11, 0, 2);
    for (int i = 0; i < 9; i++) do_txn(2'b10, 0, $urandom_range(0, 20));
    do_txn(2'b10, 0, 2);
    chk("hex_full", HEX0, 7'b0000100);
    do_txn(2'b01, 0, 4);
    do_txn(2'b10, 1, 5);
    KEY_N = 0;
    repeat (10) @(negedge CLK);
    KEY_N = 1;
    repeat (10) @(negedge CLK);
    chk("locked_press_ignored", {LEDG, LEDR, SENSOR}, 0);
    do_txn(2'b10, 0, 3);
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 7);
      do_txn(r < 4 ? 2'b10 : r < 7 ? 2'b01 : 2'b11, $urandom_range(0, 3) == 3 ? int'($urandom_range(1, 2)) : 0,
             $urandom_range(0, 20));
    end
    chk("queue_drained", q.size(), 0);
    RST_N = 0;
    @(negedge CLK);
    RST_N = 1;
    model_occ = 0;
    repeat (3) do_txn(2'b10, 0, $urandom_range(0, 10));
    @(negedge CLK) CMD = 2'b10;
    repeat (2) @(negedge CLK);
    KEY_N = 0;
    repeat (2 + DEB + 1 + 3) @(negedge CLK);
    chk("rotating_before_reset", LEDG, 1);
    RST_N = 0;
    #1;
    chk("mid_reset_occ", OCC, 0);
    chk("mid_reset_hex", HEX0, 7'b0000001);
    chk("mid_reset_leds", {SENSOR, LEDG, LEDR}, 0);
    @(negedge CLK);
    KEY_N = 1;
    CMD = 2'b00;
    RST_N = 1;
    repeat (30) @(negedge CLK);
    chk("post_reset_quiet", {SENSOR, LEDG, LEDR, OCC}, 0);
    chk("final_queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
